// File: rtl/wait_event_monitor_pkg.sv
// Shared types for the wait-event monitor: condition modes, completion status
// codes and the controller state encoding.
package wait_event_monitor_pkg;

    localparam int C_MODE_NB = 5;

    typedef enum logic [2:0] {
        MODE_RISE  = 3'd0,
        MODE_FALL  = 3'd1,
        MODE_HIGH  = 3'd2,
        MODE_LOW   = 3'd3,
        MODE_MATCH = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        STATUS_HIT     = 2'd0,
        STATUS_TIMEOUT = 2'd1,
        STATUS_BAD_CMD = 2'd2
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/wait_event_monitor_cond_eval.sv
// Combinational condition evaluator: selects one channel and tests it for an
// edge, a level or a masked match against the armed command.
module wait_cond_eval
    import wait_event_monitor_pkg::*;
#(
    parameter int WAIT_SIZE  = 5,
    parameter int WAIT_WIDTH = 32,
    parameter int CHAN_W     = 3
) (
    input  logic [WAIT_SIZE*WAIT_WIDTH-1:0] wait_signals,
    input  logic [WAIT_SIZE-1:0]            prev_bits,
    input  logic [CHAN_W-1:0]               chan,
    input  mode_e                           mode,
    input  logic [WAIT_WIDTH-1:0]           value,
    input  logic [WAIT_WIDTH-1:0]           mask,
    output logic                            cond
);

    logic [WAIT_WIDTH-1:0] chan_word [WAIT_SIZE];
    logic [WAIT_WIDTH-1:0] sel_word;
    logic                  sel_prev;

    generate
        for (genvar gi = 0; gi < WAIT_SIZE; gi++) begin : g_chan
            assign chan_word[gi] = wait_signals[gi*WAIT_WIDTH +: WAIT_WIDTH];
        end
    endgenerate

    // An out-of-range channel selects nothing; such commands never reach WAIT.
    always_comb begin
        sel_word = '0;
        sel_prev = 1'b0;
        for (int k = 0; k < WAIT_SIZE; k++) begin
            if (CHAN_W'(k) == chan) begin
                sel_word = chan_word[k];
                sel_prev = prev_bits[k];
            end
        end
    end

    always_comb begin
        cond = 1'b0;
        case (mode)
            MODE_RISE:  cond = !sel_prev && sel_word[0];
            MODE_FALL:  cond = sel_prev && !sel_word[0];
            MODE_HIGH:  cond = sel_word[0];
            MODE_LOW:   cond = !sel_word[0];
            MODE_MATCH: cond = ((sel_word & mask) == (value & mask));
            default:    cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/wait_event_monitor.sv
// Command-driven wait monitor: arms a condition on one channel, waits for it
// (optionally bounded by a timeout) and reports the outcome with a done pulse.
module wait_event_monitor
    import wait_event_monitor_pkg::*;
#(
    parameter int  WAIT_SIZE  = 5,
    parameter int  WAIT_WIDTH = 32,
    parameter int  TIMEOUT_W  = 32,
    localparam int CHAN_W     = (WAIT_SIZE > 1) ? $clog2(WAIT_SIZE) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [WAIT_SIZE*WAIT_WIDTH-1:0] wait_signals,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [CHAN_W-1:0]               cmd_chan,
    input  logic [2:0]                      cmd_mode,
    input  logic [WAIT_WIDTH-1:0]           cmd_value,
    input  logic [WAIT_WIDTH-1:0]           cmd_mask,
    input  logic [TIMEOUT_W-1:0]            cmd_timeout,
    input  logic                            abort,
    output logic                            done_valid,
    output logic [1:0]                      done_status,
    output logic [TIMEOUT_W-1:0]            done_cycles,
    output logic [CHAN_W-1:0]               done_chan
);

    state_e                 state_reg;
    logic [WAIT_SIZE-1:0]   prev_reg;
    logic [WAIT_SIZE-1:0]   bit0_now;
    logic [CHAN_W-1:0]      chan_reg;
    mode_e                  mode_reg;
    logic [WAIT_WIDTH-1:0]  value_reg;
    logic [WAIT_WIDTH-1:0]  mask_reg;
    logic [TIMEOUT_W-1:0]   timeout_reg;
    logic [TIMEOUT_W-1:0]   counter_reg;
    logic                   cmd_ready_reg;
    logic                   done_valid_reg;
    status_e                done_status_reg;
    logic [TIMEOUT_W-1:0]   done_cycles_reg;
    logic [CHAN_W-1:0]      done_chan_reg;
    logic                   cond_hit;
    logic                   cmd_bad;
    logic                   timeout_hit;

    generate
        for (genvar gi = 0; gi < WAIT_SIZE; gi++) begin : g_bit0
            assign bit0_now[gi] = wait_signals[gi*WAIT_WIDTH];
        end
    endgenerate

    assign cmd_bad     = (32'(cmd_chan) >= WAIT_SIZE) || (cmd_mode >= 3'(C_MODE_NB));
    assign timeout_hit = (timeout_reg != '0) && (counter_reg == timeout_reg - TIMEOUT_W'(1));

    wait_cond_eval #(
        .WAIT_SIZE  (WAIT_SIZE),
        .WAIT_WIDTH (WAIT_WIDTH),
        .CHAN_W     (CHAN_W)
    ) u_cond_eval (
        .wait_signals (wait_signals),
        .prev_bits    (prev_reg),
        .chan         (chan_reg),
        .mode         (mode_reg),
        .value        (value_reg),
        .mask         (mask_reg),
        .cond         (cond_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            prev_reg        <= '0;
            chan_reg        <= '0;
            mode_reg        <= MODE_RISE;
            value_reg       <= '0;
            mask_reg        <= '0;
            timeout_reg     <= '0;
            counter_reg     <= '0;
            cmd_ready_reg   <= 1'b1;
            done_valid_reg  <= 1'b0;
            done_status_reg <= STATUS_HIT;
            done_cycles_reg <= '0;
            done_chan_reg   <= '0;
        end else begin
            // Edge detection needs the previous bit 0 even while idle.
            prev_reg       <= bit0_now;
            done_valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready_reg <= 1'b0;
                        chan_reg      <= cmd_chan;
                        value_reg     <= cmd_value;
                        mask_reg      <= cmd_mask;
                        timeout_reg   <= cmd_timeout;
                        counter_reg   <= '0;
                        if (cmd_bad) begin
                            mode_reg        <= MODE_RISE;
                            state_reg       <= S_DONE;
                            done_valid_reg  <= 1'b1;
                            done_status_reg <= STATUS_BAD_CMD;
                            done_cycles_reg <= '0;
                            done_chan_reg   <= cmd_chan;
                        end else begin
                            mode_reg  <= mode_e'(cmd_mode);
                            state_reg <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        state_reg     <= S_IDLE;
                        cmd_ready_reg <= 1'b1;
                    end else if (cond_hit) begin
                        state_reg       <= S_DONE;
                        done_valid_reg  <= 1'b1;
                        done_status_reg <= STATUS_HIT;
                        done_cycles_reg <= counter_reg;
                        done_chan_reg   <= chan_reg;
                    end else if (timeout_hit) begin
                        state_reg       <= S_DONE;
                        done_valid_reg  <= 1'b1;
                        done_status_reg <= STATUS_TIMEOUT;
                        done_cycles_reg <= timeout_reg;
                        done_chan_reg   <= chan_reg;
                    end else if (counter_reg != '1) begin
                        counter_reg <= counter_reg + TIMEOUT_W'(1);
                    end
                end
                S_DONE: begin
                    state_reg     <= S_IDLE;
                    cmd_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg     <= S_IDLE;
                    cmd_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_reg;
    assign done_valid  = done_valid_reg;
    assign done_status = done_status_reg;
    assign done_cycles = done_cycles_reg;
    assign done_chan   = done_chan_reg;

endmodule

// File: tb/tb_wait_event_monitor.sv
// Directed bench for wait_event_monitor: a transaction-level predictor checked
// every cycle, plus hand-computed latency and result expectations per scenario.
module tb_wait_event_monitor;

    localparam int WS = 5;
    localparam int WW = 32;
    localparam int TW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [WS*WW-1:0] wait_signals = '0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [2:0]      cmd_chan = '0;
    logic [2:0]      cmd_mode = '0;
    logic [WW-1:0]   cmd_value = '0;
    logic [WW-1:0]   cmd_mask = '0;
    logic [TW-1:0]   cmd_timeout = '0;
    logic            abort = 1'b0;
    logic            done_valid;
    logic [1:0]      done_status;
    logic [TW-1:0]   done_cycles;
    logic [2:0]      done_chan;

    int n_checks = 0;
    int n_fail   = 0;

    wait_event_monitor #(.WAIT_SIZE(WS), .WAIT_WIDTH(WW), .TIMEOUT_W(TW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wait_signals (wait_signals),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_chan     (cmd_chan),
        .cmd_mode     (cmd_mode),
        .cmd_value    (cmd_value),
        .cmd_mask     (cmd_mask),
        .cmd_timeout  (cmd_timeout),
        .abort        (abort),
        .done_valid   (done_valid),
        .done_status  (done_status),
        .done_cycles  (done_cycles),
        .done_chan    (done_chan)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Predictor: tracks one outstanding command by its acceptance cycle and
    // resolves it from the condition rules on each later cycle.
    function automatic bit cond_holds(input int mode, input logic [WW-1:0] word,
                                      input bit prev_b, input logic [WW-1:0] v,
                                      input logic [WW-1:0] m);
        case (mode)
            0: return !prev_b && word[0];
            1: return prev_b && !word[0];
            2: return word[0];
            3: return !word[0];
            4: return ((word ^ v) & m) == '0;
            default: return 1'b0;
        endcase
    endfunction

    int             cyc = 0;
    int             acc_c, elapsed;
    bit             outst = 0, was_valid;
    bit             m_valid = 0, m_ready = 1;
    int             m_status = 0, m_chan = 0;
    longint         m_cycles = 0;
    int             mc_chan, mc_mode, mc_to;
    logic [WW-1:0]  mc_val, mc_mask;
    logic [WS*WW-1:0] m_prev_word = '0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            outst = 0; m_valid = 0; m_ready = 1;
            m_status = 0; m_cycles = 0; m_chan = 0;
            m_prev_word = '0;
        end else begin
            was_valid = m_valid;
            m_valid   = 0;
            if (m_ready) begin
                if (cmd_valid) begin
                    m_ready = 0;
                    acc_c   = cyc;
                    mc_chan = int'(cmd_chan); mc_mode = int'(cmd_mode);
                    mc_val  = cmd_value; mc_mask = cmd_mask; mc_to = int'(cmd_timeout);
                    if (mc_chan >= WS || mc_mode > 4) begin
                        m_valid = 1; m_status = 2; m_cycles = 0; m_chan = mc_chan;
                    end else begin
                        outst = 1;
                    end
                end
            end else if (outst) begin
                elapsed = cyc - acc_c - 1;
                if (abort) begin
                    outst = 0; m_ready = 1;
                end else if (cond_holds(mc_mode, wait_signals[mc_chan*WW +: WW],
                                        m_prev_word[mc_chan*WW], mc_val, mc_mask)) begin
                    outst = 0; m_valid = 1; m_status = 0; m_cycles = elapsed; m_chan = mc_chan;
                end else if (mc_to != 0 && elapsed + 1 == mc_to) begin
                    outst = 0; m_valid = 1; m_status = 1; m_cycles = mc_to; m_chan = mc_chan;
                end
            end else if (was_valid) begin
                m_ready = 1;
            end
            m_prev_word = wait_signals;
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("cyc_done_valid",  done_valid,  m_valid);
            chk("cyc_cmd_ready",   cmd_ready,   m_ready);
            chk("cyc_done_status", done_status, m_status[1:0]);
            chk("cyc_done_cycles", done_cycles, m_cycles);
            chk("cyc_done_chan",   done_chan,   m_chan[2:0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_chan(input int k, input logic [WW-1:0] v);
        wait_signals[k*WW +: WW] = v;
    endtask

    task automatic issue(input int ch, input int md, input logic [WW-1:0] v,
                         input logic [WW-1:0] m, input int to);
        chk("ready_before_cmd", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_chan = 3'(ch); cmd_mode = 3'(md);
        cmd_value = v; cmd_mask = m; cmd_timeout = TW'(to);
        tick();
        cmd_valid = 1'b0;
    endtask

    // lat counts clock edges after the accepting edge until done_valid is seen.
    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (!done_valid && lat < 60) begin
            tick();
            lat++;
        end
        if (!done_valid) chk("done_wait_bound", 1'b0, 1'b1);
    endtask

    task automatic report(input string tag, input int lat, input int exp_lat,
                          input int exp_st, input int exp_cyc, input int exp_ch);
        $display("%s: lat=%0d status=%0d cycles=%0d chan=%0d", tag, lat, done_status, done_cycles, done_chan);
        chk({tag, "_lat"},    lat, exp_lat);
        chk({tag, "_status"}, done_status, exp_st);
        chk({tag, "_cycles"}, done_cycles, exp_cyc);
        chk({tag, "_chan"},   done_chan, exp_ch);
    endtask

    initial begin
        int lat;
        repeat (3) tick();
        chk("reset_ready", cmd_ready, 1'b1);
        chk("reset_valid", done_valid, 1'b0);
        rst_n = 1'b1;
        tick();

        // chan 0 RISE, no timeout, bit 0 rises in the 10th cycle after accept
        issue(0, 0, '0, '0, 0);
        repeat (9) tick();
        set_chan(0, 32'h1);
        wait_done(9, lat);
        report("rise_c0", lat, 10, 0, 9, 0);
        tick();
        chk("rise_ready_after", cmd_ready, 1'b1);
        set_chan(0, 32'h0); tick();

        // chan 2 MATCH on upper half, hit in 5th WAIT cycle
        set_chan(2, 32'h1234_5678); tick();
        issue(2, 4, 32'hCAFE0000, 32'hFFFF0000, 20);
        repeat (4) tick();
        set_chan(2, 32'hCAFE1234);
        wait_done(4, lat);
        report("match_c2", lat, 5, 0, 4, 2);
        tick(); set_chan(2, 32'h0); tick();

        // chan 1 HIGH, timeout 8, never true
        issue(1, 2, '0, '0, 8);
        wait_done(0, lat);
        report("timeout_c1", lat, 8, 1, 8, 1);
        tick(); tick();

        // timeout 8, condition first true at counter 7: HIT wins
        issue(1, 2, '0, '0, 8);
        repeat (7) tick();
        set_chan(1, 32'h1);
        wait_done(7, lat);
        report("late_hit_c1", lat, 8, 0, 7, 1);
        tick(); set_chan(1, 32'h0); tick();

        // minimum latency: LOW on chan 3 already true
        issue(3, 3, '0, '0, 0);
        wait_done(0, lat);
        report("minlat_c3", lat, 1, 0, 0, 3);
        chk("minlat_not_ready", cmd_ready, 1'b0);
        tick();
        chk("minlat_ready", cmd_ready, 1'b1);

        // FALL on chan 4
        set_chan(4, 32'h1); tick();
        issue(4, 1, '0, '0, 0);
        repeat (2) tick();
        set_chan(4, 32'h0);
        wait_done(2, lat);
        report("fall_c4", lat, 3, 0, 2, 4);
        tick(); tick();

        // bad channel: BAD_CMD one cycle after accept
        issue(7, 2, '0, '0, 0);
        wait_done(0, lat);
        report("bad_chan", lat, 0, 2, 0, 7);
        tick();
        chk("bad_ready_after", cmd_ready, 1'b1);

        // bad mode
        issue(1, 6, '0, '0, 0);
        wait_done(0, lat);
        report("bad_mode", lat, 0, 2, 0, 1);
        tick();

        // abort during WAIT
        issue(3, 2, '0, '0, 0);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        $display("abort_wait: done_valid=%0d cmd_ready=%0d", done_valid, cmd_ready);
        chk("abort_no_done", done_valid, 1'b0);
        chk("abort_ready", cmd_ready, 1'b1);
        chk("abort_status_held", done_status, 2'd2);

        // abort coincides with a hit: abort wins
        issue(4, 3, '0, '0, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        $display("abort_hit: done_valid=%0d cmd_ready=%0d", done_valid, cmd_ready);
        chk("abort_hit_no_done", done_valid, 1'b0);
        chk("abort_hit_ready", cmd_ready, 1'b1);
        tick();

        // prove done_* hold non-zero values before the reset test
        issue(2, 2, '0, '0, 3);
        wait_done(0, lat);
        report("pre_reset_to", lat, 3, 1, 3, 2);
        tick(); tick();

        // reset mid-WAIT discards the command
        issue(1, 2, '0, '0, 0);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        $display("reset_mid_wait: valid=%0d ready=%0d status=%0d cycles=%0d chan=%0d",
                 done_valid, cmd_ready, done_status, done_cycles, done_chan);
        chk("rst_valid",  done_valid, 1'b0);
        chk("rst_ready",  cmd_ready, 1'b1);
        chk("rst_status", done_status, 2'd0);
        chk("rst_cycles", done_cycles, 32'd0);
        chk("rst_chan",   done_chan, 3'd0);
        rst_n = 1'b1;
        set_chan(1, 32'h1);
        repeat (4) tick();
        chk("rst_no_late_done", done_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
